// File: rtl/cla_serial_add_ctrl_pkg.sv
// Shared types for the byte-serial CLA adder controller.
// Holds the FSM encoding and the slice width.
package cla_serial_add_ctrl_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_serial_add_ctrl_cla8.sv
// cla_8bit: two-level 8-bit carry-lookahead slice (two 4-bit groups).
// Ports: a_i/b_i addends, c0_i carry-in, s_o sum, c8_o carry-out.
module cla_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c0_i,
  output logic [7:0] s_o,
  output logic       c8_o
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic [1:0] gg;
  logic [1:0] gp;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  for (genvar n = 0; n < 2; n++) begin : g_nib
    localparam int B = 4 * n;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign gg[n]  = g[B+3] | (p[B+3] & g[B+2])
                  | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[n]  = &p[B+3:B];
  end

  // Second level: group carries straight from c0.
  assign c[0] = c0_i;
  assign c[4] = gg[0] | (gp[0] & c[0]);
  assign c[8] = gg[1] | (gp[1] & gg[0])
              | (gp[1] & gp[0] & c[0]);

  assign s_o  = p ^ c[7:0];
  assign c8_o = c[8];

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Byte-serial wide adder: one cla_8bit reused LSB-first over NWORDS bytes.
// Ports: in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout out, busy.
module cla_serial_add_ctrl
  import cla_serial_add_ctrl_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NWORDS-1:0]   a,
  input  logic [8*NWORDS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NWORDS-1:0]   sum,
  output logic                  cout,
  output logic                  busy
);

  localparam int W  = SLICE_W * NWORDS;
  localparam int CW = $clog2(NWORDS + 1);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_c;
  logic [W-1:0]       sum_sh;

  cla_8bit u_cla (
    .a_i  (a_q[SLICE_W-1:0]),
    .b_i  (b_q[SLICE_W-1:0]),
    .c0_i (carry_q),
    .s_o  (slice_s),
    .c8_o (slice_c)
  );

  // New byte enters at the MSB end; after NWORDS shifts
  // byte 0 has reached the bottom.
  if (NWORDS == 1) begin : g_one
    assign sum_sh = slice_s;
  end else begin : g_many
    assign sum_sh = {slice_s, sum_q[W-1:SLICE_W]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        sum_d   = sum_sh;
        carry_d = slice_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NWORDS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule
